// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the adder-result accumulator.
// Derived accumulator width is DATA_W + NUM_LOG2 so a full block can never wrap.
package sum_acc_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_LOG2 = 3;
    localparam int DEF_ACC_W    = DEF_DATA_W + DEF_NUM_LOG2;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/fin_edge_det.sv
// Rising-edge detector for the adder completion flag.
// The history register resets high so a flag already asserted at reset release is ignored.
module fin_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic fin,
    output logic fin_d,
    output logic rise
);

    logic fin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fin_q <= 1'b1;
        end else begin
            fin_q <= fin;
        end
    end

    assign fin_d = fin_q;
    assign rise  = fin & ~fin_q;

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates blocks of 2^NUM_LOG2 adder results and offers total/mean on valid/ready.
// Optional SUM_ACC_MAX_EN adds out_max, the largest result captured in each block.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_LOG2 = DEF_NUM_LOG2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          sum,
    input  logic                       fin,
    output logic [DATA_W+NUM_LOG2-1:0] out_total,
    output logic [DATA_W-1:0]          out_mean,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_LOG2:0]          count,
`ifdef SUM_ACC_MAX_EN
    output logic [DATA_W-1:0]          out_max,
`endif
    output logic                       overrun
);

    localparam int ACC_W = DATA_W + NUM_LOG2;
    localparam int CNT_W = NUM_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << NUM_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << NUM_LOG2);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;

    logic             cap;
    logic             fin_d_unused;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] acc_sum;

    fin_edge_det u_fin_edge (
        .clk   (clk),
        .rst   (rst),
        .fin   (fin),
        .fin_d (fin_d_unused),
        .rise  (cap)
    );

    assign sum_ext = ACC_W'(sum);
    assign acc_sum = acc_q + sum_ext;

`ifdef SUM_ACC_MAX_EN
    logic [DATA_W-1:0] max_run_q, max_run_d;
    logic [DATA_W-1:0] max_out_q, max_out_d;
    logic [DATA_W-1:0] sum_max;

    assign sum_max = (sum > max_run_q) ? sum : max_run_q;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        total_d   = total_q;
        count_d   = count_q;
        overrun_d = overrun_q;
`ifdef SUM_ACC_MAX_EN
        max_run_d = max_run_q;
        max_out_d = max_out_q;
`endif
        case (state_q)
            ST_ACCUM: begin
                if (cap) begin
                    if (count_q == CNT_LAST) begin
                        total_d = acc_sum;
                        acc_d   = '0;
                        count_d = CNT_FULL;
                        state_d = ST_HOLD;
`ifdef SUM_ACC_MAX_EN
                        max_out_d = sum_max;
                        max_run_d = '0;
`endif
                    end else begin
                        acc_d   = acc_sum;
                        count_d = count_q + CNT_W'(1);
`ifdef SUM_ACC_MAX_EN
                        max_run_d = sum_max;
`endif
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    // A result landing on the handshake opens the next block.
                    if (cap) begin
                        acc_d   = sum_ext;
                        count_d = CNT_W'(1);
`ifdef SUM_ACC_MAX_EN
                        max_run_d = sum;
`endif
                    end else begin
                        acc_d   = '0;
                        count_d = '0;
                    end
                end else if (cap) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            total_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
`ifdef SUM_ACC_MAX_EN
            max_run_q <= '0;
            max_out_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            total_q   <= total_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
`ifdef SUM_ACC_MAX_EN
            max_run_q <= max_run_d;
            max_out_q <= max_out_d;
`endif
        end
    end

    assign out_total = total_q;
    assign out_mean  = DATA_W'(total_q >> NUM_LOG2);
    assign out_valid = (state_q == ST_HOLD);
    assign count     = count_q;
    assign overrun   = overrun_q;
`ifdef SUM_ACC_MAX_EN
    assign out_max   = max_out_q;
`endif

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: block totals are predicted as results are driven.
module tb_sum_accumulator;

    localparam int DW = 16;
    localparam int NL = 3;
    localparam int AW = DW + NL;
    localparam int N  = 1 << NL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fin = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] sum = '0;
    logic [AW-1:0] out_total;
    logic [DW-1:0] out_mean;
    logic          out_valid;
    logic [NL:0]   count;
    logic          overrun;
`ifdef SUM_ACC_MAX_EN
    logic [DW-1:0] out_max;
    logic [DW-1:0] exp_max_q[$];
`endif

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] blk_acc = '0;
    logic [DW-1:0] blk_max = '0;
    int            mcnt = 0;

    sum_accumulator #(.DATA_W(DW), .NUM_LOG2(NL)) dut (
        .clk       (clk),
        .rst       (rst),
        .sum       (sum),
        .fin       (fin),
        .out_total (out_total),
        .out_mean  (out_mean),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
`ifdef SUM_ACC_MAX_EN
        .out_max   (out_max),
`endif
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: accumulate an accepted result, push a prediction on block completion.
    task automatic note(input logic [DW-1:0] v);
        blk_acc = blk_acc + AW'(v);
        if (v > blk_max) blk_max = v;
        mcnt++;
        if (mcnt == N) begin
            exp_q.push_back(blk_acc);
`ifdef SUM_ACC_MAX_EN
            exp_max_q.push_back(blk_max);
`endif
            blk_acc = '0;
            blk_max = '0;
            mcnt    = 0;
        end
    endtask

    task automatic model_clear();
        blk_acc = '0;
        blk_max = '0;
        mcnt    = 0;
        exp_q.delete();
`ifdef SUM_ACC_MAX_EN
        exp_max_q.delete();
`endif
    endtask

    // fin high for `hold` cycles (sum garbage after the first), then low for one cycle.
    task automatic drive_result(input logic [DW-1:0] v, input int hold);
        fin = 1'b1;
        sum = v;
        step();
        sum = DW'($urandom);
        repeat (hold - 1) step();
        fin = 1'b0;
        step();
    endtask

    task automatic take_block(input string name);
        int t = 0;
        logic [AW-1:0] et;
        while (!out_valid && t < 100) begin
            step();
            t++;
        end
        checks++;
        if (!out_valid) begin
            $display("FAIL %s_valid_timeout: out_valid=%0b required 1", name, out_valid);
            errors++;
        end else if (exp_q.size() == 0) begin
            $display("FAIL %s_scoreboard: out_valid=1 but no block expected", name);
            errors++;
        end else begin
            et = exp_q.pop_front();
            checks++;
            if (out_total !== et) begin
                $display("FAIL %s_total: got %0d required %0d", name, out_total, et);
                errors++;
            end
            checks++;
            if (out_mean !== DW'(et >> NL)) begin
                $display("FAIL %s_mean: got %0d required %0d", name, out_mean, et >> NL);
                errors++;
            end
            checks++;
            if (count !== (NL+1)'(N)) begin
                $display("FAIL %s_count_hold: got %0d required %0d", name, count, N);
                errors++;
            end
`ifdef SUM_ACC_MAX_EN
            begin
                logic [DW-1:0] em;
                em = exp_max_q.pop_front();
                checks++;
                if (out_max !== em) begin
                    $display("FAIL %s_max: got %0d required %0d", name, out_max, em);
                    errors++;
                end
            end
`endif
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== '0) begin
            $display("FAIL %s_after_handshake: valid=%0b count=%0d required 0 0", name, out_valid, count);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (out_total !== '0 || out_mean !== '0 || out_valid !== 1'b0 || count !== '0 || overrun !== 1'b0) begin
            $display("FAIL reset_values: total=%0d mean=%0d valid=%0b count=%0d overrun=%0b required all 0",
                     out_total, out_mean, out_valid, count, overrun);
            errors++;
        end
        rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || count !== '0) begin
            $display("FAIL reset_release: valid=%0b count=%0d required 0 0", out_valid, count);
            errors++;
        end
    endtask

    task automatic test_const();
        for (int i = 0; i < N - 1; i++) begin
            drive_result(16'd4444, 1);
            note(16'd4444);
            checks++;
            if (count !== (NL+1)'(i + 1)) begin
                $display("FAIL const_count: got %0d required %0d", count, i + 1);
                errors++;
            end
        end
        fin = 1'b1;
        sum = 16'd4444;
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL const_valid_early: got %0b required 0", out_valid);
            errors++;
        end
        step();
        note(16'd4444);
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL const_valid_latency: got %0b required 1", out_valid);
            errors++;
        end
        fin = 1'b0;
        step();
        checks++;
        if (overrun !== 1'b0) begin
            $display("FAIL const_overrun: got %0b required 0", overrun);
            errors++;
        end
        take_block("const");
    endtask

    task automatic test_max_val();
        for (int i = 0; i < N; i++) begin
            drive_result(16'hFFFF, 1);
            note(16'hFFFF);
        end
        take_block("maxval");
    endtask

    task automatic test_held_fin();
        logic [DW-1:0] vals [N];
        vals = '{16'd4444, 16'd13332, 16'd22220, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        for (int i = 0; i < N; i++) begin
            drive_result(vals[i], 3);
            note(vals[i]);
            if (i == 2) begin
                checks++;
                if (count !== 4'd3) begin
                    $display("FAIL held_count: got %0d required 3", count);
                    errors++;
                end
            end
        end
        take_block("held");
    endtask

    task automatic test_overrun();
        logic [AW-1:0] et;
        for (int i = 0; i < N; i++) begin
            drive_result(DW'(1000 + 7 * i), 1);
            note(DW'(1000 + 7 * i));
        end
        et = exp_q[0];
        drive_result(16'd9999, 1);
        drive_result(16'd8888, 1);
        repeat (16) step();
        checks++;
        if (out_valid !== 1'b1 || count !== 4'd8 || out_total !== et) begin
            $display("FAIL overrun_hold: valid=%0b count=%0d total=%0d required 1 8 %0d",
                     out_valid, count, out_total, et);
            errors++;
        end
        checks++;
        if (overrun !== 1'b1) begin
            $display("FAIL overrun_flag: got %0b required 1", overrun);
            errors++;
        end
        take_block("overrun");
        checks++;
        if (overrun !== 1'b1) begin
            $display("FAIL overrun_sticky: got %0b required 1", overrun);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] et;
        for (int i = 0; i < N; i++) begin
            drive_result(DW'(50 * i + 3), 1);
            note(DW'(50 * i + 3));
        end
        et = exp_q.pop_front();
`ifdef SUM_ACC_MAX_EN
        void'(exp_max_q.pop_front());
`endif
        checks++;
        if (out_valid !== 1'b1 || out_total !== et) begin
            $display("FAIL b2b_first: valid=%0b total=%0d required 1 %0d", out_valid, out_total, et);
            errors++;
        end
        out_ready = 1'b1;
        fin = 1'b1;
        sum = 16'd1111;
        step();
        note(16'd1111);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd1) begin
            $display("FAIL b2b_handshake_cap: valid=%0b count=%0d required 0 1", out_valid, count);
            errors++;
        end
        fin = 1'b0;
        sum = DW'($urandom);
        step();
        for (int i = 0; i < N - 1; i++) begin
            drive_result(DW'(200 + i), 1);
            note(DW'(200 + i));
        end
        take_block("b2b");
    endtask

    task automatic test_rst_midblock();
        for (int i = 0; i < 5; i++) drive_result(DW'(3000 + i), 1);
        rst = 1'b1;
        fin = 1'b1;
        sum = 16'd777;
        step();
        model_clear();
        checks++;
        if (out_total !== '0 || out_mean !== '0 || out_valid !== 1'b0 || count !== '0 || overrun !== 1'b0) begin
            $display("FAIL rst_mid_values: total=%0d mean=%0d valid=%0b count=%0d overrun=%0b required all 0",
                     out_total, out_mean, out_valid, count, overrun);
            errors++;
        end
        rst = 1'b0;
        step();
        step();
        checks++;
        if (count !== '0) begin
            $display("FAIL rst_release_fin_high: count=%0d required 0", count);
            errors++;
        end
        fin = 1'b0;
        step();
        for (int i = 0; i < N; i++) begin
            drive_result(DW'(321 * (i + 1)), 1);
            note(DW'(321 * (i + 1)));
        end
        take_block("rst_mid");
    endtask

    initial begin
        test_reset();
        test_const();
        test_max_val();
        test_held_fin();
        test_overrun();
        test_back_to_back();
        test_rst_midblock();
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_empty: %0d blocks outstanding required 0", exp_q.size());
            errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
